// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
// State encoding, error codes and byte-order helpers.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Big-endian: first byte on the wire is the high byte.
  localparam int HI_LSB = 8;
  localparam int LO_LSB = 0;

  function automatic logic [15:0] make_word(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return (16'(hi) << HI_LSB) | (16'(lo) << LO_LSB);
  endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Idle-cycle watchdog: counts enabled cycles since the last reload.
// Ports: clock, reset_n, reload, enable in; expired out.
module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  // expired is high in the TIMEOUT_CYCLES-th idle cycle, so the
  // owner leaves on the edge that closes that cycle.
  assign expired = enable &&
    (count >= W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (reload) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Byte-stream program loader: assembles big-endian words, writes
// them to instruction memory, verifies checksum, releases cpu_reset.
module rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_in,
  output logic                  mem_load,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code
);

  state_t state, state_next;

  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [15:0] remaining;
  logic [7:0]  sum;
  logic        fire;
  logic        wd_expired;
  logic        restart;
  logic [15:0] len_word;
  logic        len_big;

  assign fire     = in_valid && in_ready;
  assign len_word = make_word(len_hi, in_data);
  assign len_big  = {16'd0, len_word} > (32'd1 << ADDR_WIDTH);
  assign restart  = start &&
    (state == S_IDLE || state == S_DONE || state == S_ERROR);

  // Held in reload while not receiving, so every entry into a
  // receive state starts from a full budget.
  watchdog_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .reset_n(reset_n),
    .reload (fire || !in_ready),
    .enable (in_ready),
    .expired(wd_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (fire) state_next = S_LEN_LO;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_LEN_LO: begin
        if (fire) begin
          if (len_big) state_next = S_ERROR;
          else if (len_word == 16'd0) state_next = S_CHECK;
          else state_next = S_DATA_HI;
        end else if (wd_expired) begin
          state_next = S_ERROR;
        end
      end
      S_DATA_HI: begin
        if (fire) state_next = S_DATA_LO;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_DATA_LO: begin
        if (fire) state_next = S_WRITE;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_WRITE: begin
        if (remaining == 16'd1) state_next = S_CHECK;
        else state_next = S_DATA_HI;
      end
      S_CHECK: begin
        if (fire) begin
          if (in_data == sum) state_next = S_DONE;
          else state_next = S_ERROR;
        end else if (wd_expired) begin
          state_next = S_ERROR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_load  = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI,
      S_DATA_LO, S_CHECK: in_ready = 1'b1;
      S_WRITE: mem_load = 1'b1;
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_hi      <= '0;
      data_hi     <= '0;
      remaining   <= '0;
      sum         <= '0;
      mem_address <= '0;
      mem_in      <= '0;
      error_code  <= ERR_NONE;
    end else begin
      if (restart) begin
        remaining   <= '0;
        sum         <= '0;
        mem_address <= '0;
        error_code  <= ERR_NONE;
      end
      if (fire && state != S_CHECK) begin
        sum <= sum + in_data;
      end
      if (fire && state == S_LEN_HI) len_hi <= in_data;
      if (fire && state == S_LEN_LO) remaining <= len_word;
      if (fire && state == S_DATA_HI) data_hi <= in_data;
      if (fire && state == S_DATA_LO) begin
        mem_in <= make_word(data_hi, in_data);
      end
      if (state == S_WRITE) begin
        mem_address <= mem_address + 1'b1;
        remaining   <= remaining - 16'd1;
      end
      if (state_next == S_ERROR && state != S_ERROR) begin
        if (fire && state == S_LEN_LO) error_code <= ERR_LEN;
        else if (fire && state == S_CHECK) error_code <= ERR_CHK;
        else error_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule
